// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Package   : core_pkg
// Purpose   : Definitions shared by the sequencer and the stage modules:
//             opcode constants, the sequencer state encoding and fault codes.
// Ports     : none (package)
// Revision  : 1.0 - initial release
// ============================================================================
package core_pkg;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_LUI         = 7'b0110111;
  localparam logic [6:0] OP_AIUPC       = 7'b0010111;
  localparam logic [6:0] OP_JAL         = 7'b1101111;
  localparam logic [6:0] OP_JALR        = 7'b1100111;
  localparam logic [6:0] OP_BRANCH      = 7'b1100011;
  localparam logic [6:0] OP_LOAD        = 7'b0000011;
  localparam logic [6:0] OP_STORE       = 7'b0100011;
  localparam logic [6:0] OP_INTEGER_IMM = 7'b0010011;
  localparam logic [6:0] OP_INTEGER     = 7'b0110011;
  localparam logic [6:0] OP_FENCE       = 7'b0001111;  // executes as a no-op
  localparam logic [6:0] OP_SYSTEM      = 7'b1110011;  // halts the core

  // Sequencer states
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM    = 4'd4,
    ST_WB     = 4'd5,
    ST_RETIRE = 4'd6,
    ST_HALT   = 4'd7,
    ST_FAULT  = 4'd8
  } state_e;

  // Fault codes reported on fault_code
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage : core_pkg
`default_nettype wire

// File: rtl/op_class.sv
`default_nettype none
// ============================================================================
// Module    : op_class
// Purpose   : Combinational opcode classifier used by the stage sequencer.
// Ports     : op_i         - 7-bit major opcode
//             legal_o      - opcode is one of the supported opcodes
//             uses_mem_o   - instruction visits the memory stage
//             is_load_o    - memory access is a load (result written back)
//             needs_wb_o   - instruction writes the register file
//             is_system_o  - SYSTEM opcode (halts the core)
// Revision  : 1.0 - initial release
// ============================================================================
module op_class
  import core_pkg::*;
(
  input  logic [6:0] op_i,
  output logic       legal_o,
  output logic       uses_mem_o,
  output logic       is_load_o,
  output logic       needs_wb_o,
  output logic       is_system_o
);

  always_comb begin
    legal_o     = 1'b1;
    uses_mem_o  = 1'b0;
    is_load_o   = 1'b0;
    needs_wb_o  = 1'b0;
    is_system_o = 1'b0;
    case (op_i)
      OP_LUI, OP_AIUPC, OP_JAL, OP_JALR,
      OP_INTEGER_IMM, OP_INTEGER: needs_wb_o = 1'b1;
      OP_LOAD: begin
        uses_mem_o = 1'b1;
        is_load_o  = 1'b1;
        needs_wb_o = 1'b1;
      end
      OP_STORE:          uses_mem_o  = 1'b1;
      OP_BRANCH, OP_FENCE: ;  // no memory access, no writeback
      OP_SYSTEM:         is_system_o = 1'b1;
      default:           legal_o     = 1'b0;
    endcase
  end

endmodule : op_class
`default_nettype wire

// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module    : stage_sequencer
// Purpose   : Multi-cycle control FSM. Steps one instruction at a time through
//             fetch/decode/execute/memory/writeback, handshaking each stage
//             with en/ready, retires and counts instructions, halts on SYSTEM
//             and faults on illegal opcodes or stage timeouts.
// Ports     : clk, rst_n      - clock, synchronous active-low reset
//             run             - keep issuing instructions (sampled in IDLE/RETIRE)
//             op              - opcode, valid while decode_ready=1
//             *_ready         - per-stage completion
//             *_en            - per-stage enable (registered)
//             pc_update       - one-cycle retire pulse
//             busy            - not in IDLE, HALT or FAULT
//             halted, fault   - sticky status; fault_code 01 illegal, 10 timeout
//             instret         - retired-instruction count (wraps)
// Revision  : 1.0 - initial release
// ============================================================================
module stage_sequencer
  import core_pkg::*;
#(
  // Cycles allowed in one stage state before a timeout fault (1..255)
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [6:0]  op,
  input  logic        fetch_ready,
  input  logic        decode_ready,
  input  logic        exec_ready,
  input  logic        mem_ready,
  input  logic        wb_ready,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        pc_update,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] instret
);

  // The watchdog holds the count of ready=0 cycles already spent in the
  // state; seeing this value with ready still low means the limit is hit.
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [6:0]  op_q, op_d;
  logic [7:0]  wd_q, wd_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [31:0] instret_q;
  logic        fetch_en_q, decode_en_q, exec_en_q, mem_en_q, wb_en_q;
  logic        pc_update_q, busy_q, halted_q, fault_q;

  logic        in_stage;
  logic        stage_ready;

  // In DECODE the incoming opcode is classified so the fault/halt decision
  // is made in the same cycle it is latched; afterwards the latched copy.
  logic [6:0]  cls_op;
  logic        cls_legal, cls_uses_mem, cls_is_load, cls_needs_wb, cls_is_system;

  assign cls_op = (state_q == ST_DECODE) ? op : op_q;

  op_class u_op_class (
    .op_i        (cls_op),
    .legal_o     (cls_legal),
    .uses_mem_o  (cls_uses_mem),
    .is_load_o   (cls_is_load),
    .needs_wb_o  (cls_needs_wb),
    .is_system_o (cls_is_system)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    fault_code_d = fault_code_q;
    in_stage     = 1'b0;
    stage_ready  = 1'b0;

    unique case (state_q)
      ST_IDLE: if (run) state_d = ST_FETCH;

      ST_FETCH: begin
        in_stage    = 1'b1;
        stage_ready = fetch_ready;
        if (fetch_ready) state_d = ST_DECODE;
      end

      ST_DECODE: begin
        in_stage    = 1'b1;
        stage_ready = decode_ready;
        if (decode_ready) begin
          op_d = op;
          if (!cls_legal) begin
            state_d      = ST_FAULT;
            fault_code_d = FAULT_ILLEGAL;
          end else if (cls_is_system) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        in_stage    = 1'b1;
        stage_ready = exec_ready;
        if (exec_ready) begin
          if (cls_uses_mem)      state_d = ST_MEM;
          else if (cls_needs_wb) state_d = ST_WB;
          else                   state_d = ST_RETIRE;
        end
      end

      ST_MEM: begin
        in_stage    = 1'b1;
        stage_ready = mem_ready;
        if (mem_ready) state_d = cls_is_load ? ST_WB : ST_RETIRE;
      end

      ST_WB: begin
        in_stage    = 1'b1;
        stage_ready = wb_ready;
        if (wb_ready) state_d = ST_RETIRE;
      end

      ST_RETIRE: state_d = run ? ST_FETCH : ST_IDLE;

      ST_HALT, ST_FAULT: ;  // sticky until reset

      default: state_d = ST_IDLE;
    endcase

    // Timeout only fires while ready is low, so a ready arriving on the
    // limit cycle takes the normal transition above.
    if (in_stage && !stage_ready && (wd_q == WD_LIMIT)) begin
      state_d      = ST_FAULT;
      fault_code_d = FAULT_TIMEOUT;
    end

    if (state_d != state_q)          wd_d = 8'd0;
    else if (in_stage && !stage_ready) wd_d = wd_q + 8'd1;
    else                             wd_d = wd_q;
  end

  // --------------------------------------------------------------------------
  // State and registered outputs. Outputs are decoded from the next state and
  // registered, so each equals a decode of state_q with no path from ready.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= 7'd0;
      wd_q         <= 8'd0;
      fault_code_q <= FAULT_NONE;
      instret_q    <= 32'd0;
      fetch_en_q   <= 1'b0;
      decode_en_q  <= 1'b0;
      exec_en_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      wb_en_q      <= 1'b0;
      pc_update_q  <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wd_q         <= wd_d;
      fault_code_q <= fault_code_d;
      fetch_en_q   <= (state_d == ST_FETCH);
      decode_en_q  <= (state_d == ST_DECODE);
      exec_en_q    <= (state_d == ST_EXEC);
      mem_en_q     <= (state_d == ST_MEM);
      wb_en_q      <= (state_d == ST_WB);
      pc_update_q  <= (state_d == ST_RETIRE);
      busy_q       <= !(state_d inside {ST_IDLE, ST_HALT, ST_FAULT});
      halted_q     <= (state_d == ST_HALT);
      fault_q      <= (state_d == ST_FAULT);
      // RETIRE never repeats back-to-back, so this counts once per retire.
      if (state_d == ST_RETIRE) instret_q <= instret_q + 32'd1;
    end
  end

  assign fetch_en   = fetch_en_q;
  assign decode_en  = decode_en_q;
  assign exec_en    = exec_en_q;
  assign mem_en     = mem_en_q;
  assign wb_en      = wb_en_q;
  assign pc_update  = pc_update_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign instret    = instret_q;

endmodule : stage_sequencer
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : tb_stage_sequencer
// Purpose   : Self-checking bench for stage_sequencer. Stage responders answer
//             ready after a programmable number of en cycles (writeback ready
//             is wb_en registered); a scoreboard holds per-instruction
//             expectations that are checked at each retire pulse.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_stage_sequencer;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, run;
  logic [6:0]  op;
  logic        fetch_ready, decode_ready, exec_ready, mem_ready, wb_ready;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
  logic        pc_update, busy, halted, fault;
  logic [1:0]  fault_code;
  logic [31:0] instret;

  always #5 clk = ~clk;

  stage_sequencer #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .op(op),
    .fetch_ready(fetch_ready), .decode_ready(decode_ready),
    .exec_ready(exec_ready), .mem_ready(mem_ready), .wb_ready(wb_ready),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
    .mem_en(mem_en), .wb_en(wb_en), .pc_update(pc_update), .busy(busy),
    .halted(halted), .fault(fault), .fault_code(fault_code), .instret(instret)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------- stage responders ----------------
  // tgt[s] = en cycle (1-based) in which ready is raised; 0 = never.
  int         tgt [4] = '{2, 2, 2, 2};
  int         rcnt[4] = '{0, 0, 0, 0};
  logic [3:0] rdy4 = '0;
  logic       wb_q = 1'b0;
  logic [3:0] en4;

  assign en4          = {mem_en, exec_en, decode_en, fetch_en};
  assign fetch_ready  = rdy4[0];
  assign decode_ready = rdy4[1];
  assign exec_ready   = rdy4[2];
  assign mem_ready    = rdy4[3];
  assign wb_ready     = wb_q;

  always @(posedge clk) begin
    for (int s = 0; s < 4; s++) begin
      rdy4[s] <= en4[s] && !rdy4[s] && (rcnt[s] + 2 == tgt[s]);
      rcnt[s] <= en4[s] ? rcnt[s] + 1 : 0;
    end
    wb_q <= wb_en;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int mem;
    int wb;
    int lat;
    int ir;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;
  int   exp_ir = 0;

  function automatic int cls_mem(input logic [6:0] o);
    return ((o == OP_LOAD) || (o == OP_STORE)) ? 1 : 0;
  endfunction

  function automatic int cls_wb(input logic [6:0] o);
    case (o)
      OP_LUI, OP_AIUPC, OP_JAL, OP_JALR, OP_INTEGER_IMM, OP_INTEGER, OP_LOAD: return 1;
      default: return 0;
    endcase
  endfunction

  // Cycles from first fetch_en to the retire cycle inclusive: each visited
  // stage dwells tgt cycles, writeback 2 (ready is en delayed), retire 1.
  task automatic push_exp(input logic [6:0] o);
    exp_t e;
    exp_ir++;
    e.mem = cls_mem(o);
    e.wb  = cls_wb(o);
    e.lat = tgt[0] + tgt[1] + tgt[2] + (e.mem ? tgt[3] : 0) + (e.wb ? 2 : 0) + 1;
    e.ir  = exp_ir;
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0;
  logic [4:0] en_prev = '0;
  logic [4:0] en_now;
  int         n_en[5];
  int         last_idx = 0;
  int         order_err = 0;
  int         t_start = 0;
  int         mem_entry = 0;
  int         fault_cyc = 0;
  logic       fault_prev = 1'b0;
  logic       ir_pending = 1'b0;
  int         ir_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    en_now = {wb_en, mem_en, exec_en, decode_en, fetch_en};
    if (ir_pending) begin
      chk("instret", instret, ir_exp);
      ir_pending = 1'b0;
    end
    for (int s = 0; s < 5; s++) begin
      if (en_now[s] && !en_prev[s]) begin
        if (s == 0) begin
          n_en      = '{default: 0};
          last_idx  = 0;
          order_err = 0;
          t_start   = cyc;
        end else begin
          if (s <= last_idx) order_err++;
          last_idx = s;
        end
        n_en[s]++;
        if (s == 3) mem_entry = cyc;
      end
    end
    if (fault && !fault_prev) fault_cyc = cyc;
    fault_prev = fault;
    if (pc_update) begin
      if (sb.size() == 0) begin
        chk("sb_pop", sb.size(), 1);
      end else begin
        e_pop = sb.pop_front();
        chk("fetch_en_cnt",  n_en[0], 1);
        chk("decode_en_cnt", n_en[1], 1);
        chk("exec_en_cnt",   n_en[2], 1);
        chk("mem_en_cnt",    n_en[3], e_pop.mem);
        chk("wb_en_cnt",     n_en[4], e_pop.wb);
        chk("en_order",      order_err, 0);
        chk("latency",       cyc - t_start + 1, e_pop.lat);
        ir_pending = 1'b1;
        ir_exp     = e_pop.ir;
      end
    end
    en_prev = en_now;
  end

  // ---------------- helpers ----------------
  // Waits for n retire pulses; run drops in the last retire cycle.
  task automatic wait_pulses(input int n, input int budget);
    int got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (pc_update) got++;
    end
    run = 1'b0;
    chk("retire_count", got, n);
    repeat (2) @(negedge clk);
    chk("idle_after_run0", busy, 0);
  endtask

  task automatic issue(input logic [6:0] o, input int n, input int budget);
    op = o;
    for (int i = 0; i < n; i++) push_exp(o);
    run = 1'b1;
    wait_pulses(n, budget);
  endtask

  task automatic wait_fault(input int budget);
    for (int c = 0; c < budget && !fault; c++) @(negedge clk);
    chk("fault_seen", fault, 1);
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ir = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    op    = 7'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_enables", {fetch_en, decode_en, exec_en, mem_en, wb_en}, 0);
    chk("rst_pc_update", pc_update, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fault_code", fault_code, 0);
    chk("rst_instret", instret, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back ALU ops, then SYSTEM halts without retiring.
    issue(OP_INTEGER, 3, 100);
    op  = OP_SYSTEM;
    run = 1'b1;
    for (int c = 0; c < 50 && !halted; c++) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("halted", halted, 1);
    chk("halt_instret", instret, 3);
    chk("halt_busy", busy, 0);
    chk("halt_fault", fault, 0);

    do_reset();
    issue(OP_LOAD,   1, 60);
    issue(OP_STORE,  1, 60);
    issue(OP_BRANCH, 1, 60);
    issue(OP_FENCE,  1, 60);
    issue(OP_LUI,    1, 60);

    // Illegal opcode.
    op  = 7'b1111111;
    run = 1'b1;
    wait_fault(60);
    chk("illegal_code", fault_code, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fault_enables", {fetch_en, decode_en, exec_en, mem_en, wb_en}, 0);
    end
    chk("fault_instret", instret, 5);
    chk("fault_busy", busy, 0);

    // Memory stage never ready: timeout 255 cycles after entering MEM.
    do_reset();
    tgt[3] = 0;
    op  = OP_LOAD;
    run = 1'b1;
    wait_fault(400);
    chk("timeout_delay", fault_cyc - mem_entry, 255);
    chk("timeout_code", fault_code, 2'b10);
    chk("timeout_enables", {fetch_en, decode_en, exec_en, mem_en, wb_en}, 0);

    // Ready arriving on the limit cycle wins.
    do_reset();
    tgt[3] = 255;
    issue(OP_LOAD, 1, 400);
    chk("limit_no_fault", fault, 0);
    tgt[3] = 2;

    // Reset in EXEC, then fetch resumes; run drops mid-instruction.
    tgt[2] = 50;
    op  = OP_INTEGER;
    run = 1'b1;
    for (int c = 0; c < 50 && !exec_en; c++) @(negedge clk);
    chk("reached_exec", exec_en, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_enables", {fetch_en, decode_en, exec_en, mem_en, wb_en}, 0);
    chk("midrst_instret", instret, 0);
    chk("midrst_busy", busy, 0);
    rst_n  = 1'b1;
    exp_ir = 0;
    @(negedge clk);
    chk("midrst_fetch", fetch_en, 1);
    push_exp(OP_INTEGER);
    run = 1'b0;
    wait_pulses(1, 150);
    tgt[2] = 2;

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got=%0d expected=%0d", total, 0);
    $fatal(1);
  end

endmodule : tb_stage_sequencer
`default_nettype wire
